// File: rtl/jacobi_result_sender_pkg.sv
// Shared types and sizing for the Jacobi result sender: FSM encoding and output FIFO depth.
// Default widths match the Jacobi core's output word, RAM address and transfer length.
package jacobi_result_sender_pkg;

    localparam int JACOBI_OUTPUT_WORD_WIDTH = 32;
    localparam int JACOBI_ADDR_WIDTH        = 8;
    localparam int JACOBI_N_INPUT_DATA      = 16;
    localparam int JACOBI_OUT_FIFO_DEPTH    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } jacobi_sender_fsm_t;

endpackage

// File: rtl/jacobi_out_fifo.sv
// Small synchronous FIFO between RAM read data and the microcontroller valid/ready port.
// Head entry comes straight from storage registers, so dout is registered.
module jacobi_out_fifo
    import jacobi_result_sender_pkg::*;
#(
    parameter int WORD_W = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int DEPTH  = JACOBI_OUT_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jacobi_result_sender.sv
// Streams N_WORDS result words from the Jacobi RAM to the microcontroller over valid/ready.
// Reads are credit-limited so the 2-entry FIFO absorbs RAM latency under backpressure.
module jacobi_result_sender
    import jacobi_result_sender_pkg::*;
#(
    parameter int WORD_W    = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int ADDR_W    = JACOBI_ADDR_WIDTH,
    parameter int N_WORDS   = JACOBI_N_INPUT_DATA,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [WORD_W-1:0] ram_dout_i,
    output logic [WORD_W-1:0] out_dat_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i
);

    // state | meaning
    // IDLE  | waiting for start_i
    // READ  | issuing RAM reads as FIFO credit allows
    // DRAIN | all reads issued, waiting for remaining handshakes
    // DONE  | one-cycle done_o pulse, counters cleared

    localparam int CNT_W     = $clog2(N_WORDS + 1);
    localparam int FCNT_W    = $clog2(JACOBI_OUT_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(N_WORDS);

    jacobi_sender_fsm_t state;
    jacobi_sender_fsm_t state_next;

    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  sent_cnt;
    logic              inflight;
    logic              pop;
    logic [2:0]        occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    assign pop        = out_vld_o & out_rdy_i;
    assign out_vld_o  = ~fifo_empty;
    // Slots already taken or promised once this cycle's pop is accounted for.
    assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign ram_addr_o = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt);

    jacobi_out_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (JACOBI_OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (out_rdy_i),
        .din   (ram_dout_i),
        .dout  (out_dat_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state;
        ram_en_o   = 1'b0;
        busy_o     = (state != IDLE);
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                ram_en_o = (rd_cnt != CNT_ALL) && (occupancy < 3'(JACOBI_OUT_FIFO_DEPTH))
                           && ~fifo_full;
                if (pop && (sent_cnt == CNT_LAST)) begin
                    state_next = DONE;
                end else if (ram_en_o && (rd_cnt == CNT_LAST)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (sent_cnt == CNT_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            sent_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= ram_en_o;
            if (state == DONE) begin
                rd_cnt   <= '0;
                sent_cnt <= '0;
            end else begin
                if (ram_en_o) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (pop) begin
                    sent_cnt <= sent_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jacobi_result_sender.sv
// Directed bench for jacobi_result_sender: a 16-word instance and a 1-word instance at base 5.
// RAM model returns address+100 one cycle after each read enable.
module tb_jacobi_result_sender;

    localparam int WW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_a, busy_a, done_a, en_a, vld_a, rdy_a;
    logic [AW-1:0] addr_a;
    logic [WW-1:0] rdat_a, dat_a;
    logic          start_b, busy_b, done_b, en_b, vld_b, rdy_b;
    logic [AW-1:0] addr_b;
    logic [WW-1:0] rdat_b, dat_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    jacobi_result_sender #(.WORD_W(WW), .ADDR_W(AW), .N_WORDS(16), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .ram_en_o(en_a), .ram_addr_o(addr_a), .ram_dout_i(rdat_a),
        .out_dat_o(dat_a), .out_vld_o(vld_a), .out_rdy_i(rdy_a)
    );

    jacobi_result_sender #(.WORD_W(WW), .ADDR_W(AW), .N_WORDS(1), .BASE_ADDR(5)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .ram_en_o(en_b), .ram_addr_o(addr_b), .ram_dout_i(rdat_b),
        .out_dat_o(dat_b), .out_vld_o(vld_b), .out_rdy_i(rdy_b)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en_a) rdat_a <= WW'(addr_a) + 100;
        if (en_b) rdat_b <= WW'(addr_b) + 100;
    end

    // Observation log, sampled mid-cycle.
    int wd_a[$], hc_a[$], ea_a[$], wd_b[$], hc_b[$], ea_b[$];
    int done_a_cnt = 0, done_a_cyc = 0, done_b_cnt = 0, done_b_cyc = 0;
    int stall_err = 0;
    bit prev_stall = 0;
    logic [WW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (vld_a && rdy_a) begin wd_a.push_back(int'(dat_a)); hc_a.push_back(cyc); end
            if (en_a) ea_a.push_back(int'(addr_a));
            if (done_a) begin done_a_cnt++; done_a_cyc = cyc; end
            if (vld_b && rdy_b) begin wd_b.push_back(int'(dat_b)); hc_b.push_back(cyc); end
            if (en_b) ea_b.push_back(int'(addr_b));
            if (done_b) begin done_b_cnt++; done_b_cyc = cyc; end
            if (prev_stall && (!vld_a || dat_a !== prev_dat)) stall_err++;
            prev_stall = vld_a && !rdy_a;
            prev_dat   = dat_a;
        end
    end

    task automatic pulse_start_a(output int s);
        @(posedge clk); #1 start_a = 1'b1; s = cyc;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int d0, input int budget, input bit toggle, output bit ok);
        int n = 0;
        ok = 0;
        while (n < budget) begin
            @(negedge clk); #1;
            if (done_a_cnt > d0) begin ok = 1; break; end
            if (toggle) begin @(posedge clk); #1 rdy_a = ~rdy_a; end
            n++;
        end
    endtask

    task automatic wait_words_a(input int target, input int budget, output bit ok);
        int n = 0;
        ok = 0;
        while (n < budget) begin
            @(negedge clk); #1;
            if (wd_a.size() >= target) begin ok = 1; break; end
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 0; start_b = 0; rdy_a = 0; rdy_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_a); end
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%b want=0", en_a); end
        total++; if (addr_a !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", vld_a); end
        total++; if (addr_b !== 8'd5) begin bad++; $display("FAIL reset_addr_b got=%0d want=5", addr_b); end
        total++; if (vld_b !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_b vld=%b busy=%b want=0,0", vld_b, busy_b); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_stream();
        int s, w0, d0, e0, se0;
        bit ok;
        rdy_a = 1'b1;
        w0 = wd_a.size(); d0 = done_a_cnt; e0 = ea_a.size(); se0 = stall_err;
        pulse_start_a(s);
        wait_done_a(d0, 100, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL stream_timeout got=no_done want=done"); end
        total++; if (wd_a.size() - w0 != 16) begin bad++; $display("FAIL stream_count got=%0d want=16", wd_a.size() - w0); end
        if (wd_a.size() - w0 == 16) begin
            for (int i = 0; i < 16; i++) begin
                total++; if (wd_a[w0+i] != 100 + i) begin bad++; $display("FAIL stream_word[%0d] got=%0d want=%0d", i, wd_a[w0+i], 100 + i); end
                total++; if (hc_a[w0+i] != s + 3 + i) begin bad++; $display("FAIL stream_cycle[%0d] got=%0d want=%0d", i, hc_a[w0+i] - s, 3 + i); end
            end
        end
        total++; if (done_a_cyc != s + 19) begin bad++; $display("FAIL stream_done_cycle got=%0d want=19", done_a_cyc - s); end
        total++; if (ea_a.size() - e0 != 16) begin bad++; $display("FAIL stream_reads got=%0d want=16", ea_a.size() - e0); end
        @(negedge clk);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL stream_busy_after got=%b want=0", busy_a); end
        total++; if (stall_err != se0) begin bad++; $display("FAIL stream_stability got=%0d want=%0d", stall_err, se0); end
    endtask

    task automatic test_toggle();
        int s, w0, d0, se0;
        bit ok;
        rdy_a = 1'b1;
        w0 = wd_a.size(); d0 = done_a_cnt; se0 = stall_err;
        pulse_start_a(s);
        wait_done_a(d0, 200, 1, ok);
        rdy_a = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL toggle_timeout got=no_done want=done"); end
        total++; if (wd_a.size() - w0 != 16) begin bad++; $display("FAIL toggle_count got=%0d want=16", wd_a.size() - w0); end
        if (wd_a.size() - w0 == 16) begin
            for (int i = 0; i < 16; i++) begin
                total++; if (wd_a[w0+i] != 100 + i) begin bad++; $display("FAIL toggle_word[%0d] got=%0d want=%0d", i, wd_a[w0+i], 100 + i); end
            end
        end
        total++; if (stall_err != se0) begin bad++; $display("FAIL toggle_stability got=%0d want=%0d", stall_err, se0); end
        total++; if (done_a_cnt - d0 != 1) begin bad++; $display("FAIL toggle_done_count got=%0d want=1", done_a_cnt - d0); end
    endtask

    task automatic test_stall();
        int s, w0, d0, e0, se0;
        bit ok;
        rdy_a = 1'b0;
        w0 = wd_a.size(); d0 = done_a_cnt; e0 = ea_a.size(); se0 = stall_err;
        pulse_start_a(s);
        repeat (20) @(negedge clk);
        total++; if (ea_a.size() - e0 != 2) begin bad++; $display("FAIL stall_reads got=%0d want=2", ea_a.size() - e0); end
        if (ea_a.size() - e0 == 2) begin
            total++; if (ea_a[e0] != 0 || ea_a[e0+1] != 1) begin bad++; $display("FAIL stall_addrs got=%0d,%0d want=0,1", ea_a[e0], ea_a[e0+1]); end
        end
        total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL stall_vld got=%b want=1", vld_a); end
        total++; if (dat_a !== 32'd100) begin bad++; $display("FAIL stall_dat got=%0d want=100", dat_a); end
        @(posedge clk); #1 rdy_a = 1'b1;
        wait_done_a(d0, 100, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=no_done want=done"); end
        total++; if (wd_a.size() - w0 != 16) begin bad++; $display("FAIL stall_count got=%0d want=16", wd_a.size() - w0); end
        if (wd_a.size() - w0 == 16) begin
            for (int i = 0; i < 16; i++) begin
                total++; if (wd_a[w0+i] != 100 + i) begin bad++; $display("FAIL stall_word[%0d] got=%0d want=%0d", i, wd_a[w0+i], 100 + i); end
            end
        end
        total++; if (stall_err != se0) begin bad++; $display("FAIL stall_stability got=%0d want=%0d", stall_err, se0); end
    endtask

    task automatic test_restart_ignored();
        int s, s2, w0, d0;
        bit ok;
        rdy_a = 1'b1;
        w0 = wd_a.size(); d0 = done_a_cnt;
        pulse_start_a(s);
        wait_words_a(w0 + 5, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL restart_wait got=%0d want=5", wd_a.size() - w0); end
        pulse_start_a(s2);
        wait_done_a(d0, 100, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL restart_timeout got=no_done want=done"); end
        repeat (25) @(negedge clk);
        total++; if (wd_a.size() - w0 != 16) begin bad++; $display("FAIL restart_count got=%0d want=16", wd_a.size() - w0); end
        total++; if (done_a_cnt - d0 != 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", done_a_cnt - d0); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL restart_busy got=%b want=0", busy_a); end
    endtask

    task automatic test_reset_mid();
        int s, w0, w1, d0;
        bit ok;
        rdy_a = 1'b1;
        w0 = wd_a.size(); d0 = done_a_cnt;
        pulse_start_a(s);
        wait_words_a(w0 + 7, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_wait got=%0d want=7", wd_a.size() - w0); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL rstmid_vld got=%b want=0", vld_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy_a); end
        total++; if (en_a !== 1'b0 || addr_a !== 8'd0) begin bad++; $display("FAIL rstmid_ram en=%b addr=%0d want=0,0", en_a, addr_a); end
        repeat (10) @(negedge clk);
        total++; if (done_a_cnt != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_a_cnt, d0); end
        w1 = wd_a.size();
        pulse_start_a(s);
        wait_done_a(d0, 100, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=no_done want=done"); end
        total++; if (wd_a.size() - w1 != 16) begin bad++; $display("FAIL rstmid_count got=%0d want=16", wd_a.size() - w1); end
        if (wd_a.size() - w1 == 16) begin
            for (int i = 0; i < 16; i++) begin
                total++; if (wd_a[w1+i] != 100 + i) begin bad++; $display("FAIL rstmid_word[%0d] got=%0d want=%0d", i, wd_a[w1+i], 100 + i); end
            end
        end
    endtask

    task automatic test_single();
        int s, w0, d0, e0, n;
        rdy_b = 1'b1;
        w0 = wd_b.size(); d0 = done_b_cnt; e0 = ea_b.size();
        @(posedge clk); #1 start_b = 1'b1; s = cyc;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (done_b_cnt == d0 && n < 50) begin @(negedge clk); #1; n++; end
        total++; if (done_b_cnt - d0 != 1) begin bad++; $display("FAIL single_done got=%0d want=1", done_b_cnt - d0); end
        total++; if (ea_b.size() - e0 != 1) begin bad++; $display("FAIL single_reads got=%0d want=1", ea_b.size() - e0); end
        if (ea_b.size() - e0 == 1) begin
            total++; if (ea_b[e0] != 5) begin bad++; $display("FAIL single_addr got=%0d want=5", ea_b[e0]); end
        end
        total++; if (wd_b.size() - w0 != 1) begin bad++; $display("FAIL single_count got=%0d want=1", wd_b.size() - w0); end
        if (wd_b.size() - w0 == 1) begin
            total++; if (wd_b[w0] != 105) begin bad++; $display("FAIL single_word got=%0d want=105", wd_b[w0]); end
            total++; if (hc_b[w0] != s + 3) begin bad++; $display("FAIL single_cycle got=%0d want=3", hc_b[w0] - s); end
        end
        total++; if (done_b_cyc != s + 4) begin bad++; $display("FAIL single_done_cycle got=%0d want=4", done_b_cyc - s); end
        @(negedge clk);
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy_b); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
